// File: rtl/pe_vec_engine.sv
`default_nettype none
// ============================================================================
//  Module   : pe_vec_engine
//  Purpose  : Vector processing element with an AXI4-Lite read master.
//             Fetches two VEC_LEN-element operand vectors (A then B) one beat
//             at a time, runs one decoded vector op across all lanes in a
//             single cycle, and repeats for op_total operations. The operand
//             address keeps advancing across operations.
//  Ports    : clk, rst_n                - clock, async active-low reset
//             axi_ar* / axi_r*          - AXI4-Lite read address/data channels
//             base_addr, instruction,
//             op_total, start           - run setup, latched when leaving IDLE
//             busy, done, error         - run status
//             op_count, acc_out         - progress and dot-product accumulator
//             res_rd_idx, res_rd_data   - combinational result lane read port
//  Revision : 1.0 - initial release
// ============================================================================
module pe_vec_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int VEC_LEN        = 4,
  parameter int ACC_WIDTH      = 48,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  localparam int IDX_W         = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [2:0]                axi_arprot,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [1:0]                axi_rresp,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]               instruction,
  input  logic [7:0]                op_total,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [7:0]                op_count,
  output logic [ACC_WIDTH-1:0]      acc_out,
  input  logic [IDX_W-1:0]          res_rd_idx,
  output logic [DATA_WIDTH-1:0]     res_rd_data
);

  localparam int                      BEAT_W      = $clog2(2 * VEC_LEN);
  localparam logic [BEAT_W-1:0]       c_LAST_BEAT = BEAT_W'(2 * VEC_LEN - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
  localparam logic [IDX_W:0]          c_LANES     = (IDX_W + 1)'(VEC_LEN);

  localparam logic [3:0] c_OP_MUL  = 4'd1;
  localparam logic [3:0] c_OP_ACT  = 4'd2;
  localparam logic [3:0] c_OP_NORM = 4'd3;
  localparam logic [3:0] c_OP_DOT  = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_EXEC = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_next;

  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [3:0]                  r_opcode;
  logic [7:0]                  r_subtype;
  logic [7:0]                  r_total;
  logic [7:0]                  r_op_count;
  logic [ACC_WIDTH-1:0]        r_acc;
  logic                        r_error;
  logic [BEAT_W-1:0]           r_beat;
  logic [DATA_WIDTH-1:0]       r_a   [VEC_LEN];
  logic [DATA_WIDTH-1:0]       r_b   [VEC_LEN];
  logic [DATA_WIDTH-1:0]       r_res [VEC_LEN];

  logic [2*DATA_WIDTH-1:0]     w_prod [VEC_LEN];
  logic [DATA_WIDTH-1:0]       w_lane [VEC_LEN];
  logic [ACC_WIDTH-1:0]        w_dot_sum;
  logic                        w_op_ok;
  logic                        w_arvalid;
  logic                        w_rready;
  logic                        w_busy;
  logic                        w_done;
  logic                        w_unused_instr;

  // Opcode legality is judged on the live instruction so IDLE can branch
  // straight to DONE without issuing any read.
  assign w_op_ok = (instruction[31:28] == c_OP_MUL)  ||
                   (instruction[31:28] == c_OP_ACT)  ||
                   (instruction[31:28] == c_OP_NORM) ||
                   (instruction[31:28] == c_OP_DOT);

  assign w_unused_instr = ^instruction[27:8];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and channel control
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (!w_op_ok || (op_total == 8'd0)) begin
            w_next = S_DONE;
          end else begin
            w_next = S_AR;
          end
        end
      end
      S_AR: begin
        w_arvalid = 1'b1;
        if (axi_arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        w_rready = 1'b1;
        if (axi_rvalid) begin
          if (axi_rresp != 2'b00) begin
            w_next = S_DONE;
          end else if (r_beat == c_LAST_BEAT) begin
            w_next = S_EXEC;
          end else begin
            w_next = S_AR;
          end
        end
      end
      S_EXEC: begin
        w_next = S_NEXT;
      end
      S_NEXT: begin
        w_next = (r_op_count == r_total) ? S_DONE : S_AR;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        if (!start) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Lane datapath: full-width products feed both the MUL/DOT lane result
  // (low half) and the dot-product sum (full product, wrapped to ACC_WIDTH).
  // --------------------------------------------------------------------------
  always_comb begin
    w_dot_sum = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      w_prod[i] = {{DATA_WIDTH{1'b0}}, r_a[i]} * {{DATA_WIDTH{1'b0}}, r_b[i]};
      w_dot_sum = w_dot_sum + ACC_WIDTH'(w_prod[i]);
      case (r_opcode)
        c_OP_MUL, c_OP_DOT: w_lane[i] = w_prod[i][DATA_WIDTH-1:0];
        c_OP_ACT: begin
          if ((r_subtype == 8'd0) && r_a[i][DATA_WIDTH-1]) begin
            w_lane[i] = '0;
          end else begin
            w_lane[i] = r_a[i];
          end
        end
        default: w_lane[i] = r_a[i];
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Run registers and operand/result buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_opcode   <= '0;
      r_subtype  <= '0;
      r_total    <= '0;
      r_op_count <= '0;
      r_acc      <= '0;
      r_error    <= 1'b0;
      r_beat     <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_opcode   <= instruction[31:28];
            r_subtype  <= instruction[7:0];
            r_total    <= op_total;
            r_op_count <= '0;
            r_acc      <= '0;
            r_beat     <= '0;
            r_error    <= !w_op_ok;
          end
        end
        S_R: begin
          if (axi_rvalid) begin
            if (axi_rresp != 2'b00) begin
              // Abort leaves operands, results and accumulator as they were.
              r_error <= 1'b1;
            end else begin
              for (int i = 0; i < VEC_LEN; i++) begin
                if (r_beat == BEAT_W'(i)) begin
                  r_a[i] <= DATA_WIDTH'(axi_rdata);
                end
                if (r_beat == BEAT_W'(VEC_LEN + i)) begin
                  r_b[i] <= DATA_WIDTH'(axi_rdata);
                end
              end
              r_addr <= r_addr + c_ADDR_STEP;
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_EXEC: begin
          r_res      <= w_lane;
          r_op_count <= r_op_count + 8'd1;
          if (r_opcode == c_OP_DOT) begin
            r_acc <= r_acc + w_dot_sum;
          end
        end
        S_NEXT: begin
          r_beat <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axi_araddr  = r_addr;
  assign axi_arvalid = w_arvalid;
  assign axi_rready  = w_rready;
  assign axi_arprot  = 3'b000;
  assign busy        = w_busy;
  assign done        = w_done;
  assign error       = r_error;
  assign op_count    = r_op_count;
  assign acc_out     = r_acc;

  // Out-of-range lane selects (non power-of-two VEC_LEN) read as zero.
  assign res_rd_data = ({1'b0, res_rd_idx} < c_LANES) ? r_res[res_rd_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pe_vec_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_vec_engine
//  Purpose  : Directed self-checking bench for pe_vec_engine with a small
//             AXI4-Lite read slave (configurable AR wait, error injection).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_vec_engine;

  logic        clk;
  logic        rst_n;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [2:0]  axi_arprot;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [1:0]  axi_rresp;
  logic [31:0] base_addr;
  logic [31:0] instruction;
  logic [7:0]  op_total;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  op_count;
  logic [47:0] acc_out;
  logic [1:0]  res_rd_idx;
  logic [31:0] res_rd_data;

  pe_vec_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_arprot  (axi_arprot),
    .axi_rdata   (axi_rdata),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rresp   (axi_rresp),
    .base_addr   (base_addr),
    .instruction (instruction),
    .op_total    (op_total),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .op_count    (op_count),
    .acc_out     (acc_out),
    .res_rd_idx  (res_rd_idx),
    .res_rd_data (res_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI read slave model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addr [256];
  int          rd_cnt    = 0;
  int          rd_base   = 0;
  int          ar_wait   = 0;
  int          err_beat  = -1;
  bit          stab_err  = 1'b0;
  bit          proto_err = 1'b0;

  initial begin
    bit          ar_fire;
    bit          r_fire;
    int          wait_cnt;
    logic [31:0] cap;
    logic [31:0] hold;
    ar_fire = 0; r_fire = 0; wait_cnt = 0; cap = 0; hold = 0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rresp   = 2'b00;
        ar_fire = 0; r_fire = 0; wait_cnt = 0;
      end else begin
        if (r_fire) begin
          axi_rvalid = 1'b0;
          r_fire = 0;
        end
        if (ar_fire) begin
          if (rd_cnt < 256) rd_addr[rd_cnt] = cap;
          axi_rdata  = mem.exists(cap) ? mem[cap] : 32'hDEAD_BEEF;
          axi_rresp  = ((rd_cnt - rd_base) == err_beat) ? 2'b10 : 2'b00;
          axi_rvalid = 1'b1;
          axi_arready = 1'b0;
          rd_cnt++;
          ar_fire = 0;
          wait_cnt = 0;
        end
        if (axi_arvalid && axi_rvalid) proto_err = 1'b1;
        if (axi_arvalid && !axi_rvalid) begin
          if (wait_cnt == 0) hold = axi_araddr;
          else if (axi_araddr != hold) stab_err = 1'b1;
          if (wait_cnt >= ar_wait) begin
            axi_arready = 1'b1;
            wait_cnt++;
          end else begin
            axi_arready = 1'b0;
            wait_cnt++;
          end
        end else begin
          if (wait_cnt != 0) stab_err = 1'b1;
          axi_arready = 1'b0;
        end
        ar_fire = axi_arvalid && axi_arready;
        cap     = axi_araddr;
        r_fire  = axi_rvalid && axi_rready;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic run(input logic [31:0] base, input logic [31:0] instr, input logic [7:0] tot);
    int cyc;
    @(negedge clk);
    #2;
    base_addr   = base;
    instruction = instr;
    op_total    = tot;
    rd_base     = rd_cnt;
    start       = 1'b1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic release_start();
    @(negedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("done_cleared", {63'd0, done}, 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      res_rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_res%0d", tag, i), {32'd0, res_rd_data}, {32'd0, exp[i]});
    end
  endtask

  function automatic logic [63:0] nreads();
    return 64'(rd_cnt - rd_base);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    instruction = '0;
    op_total    = '0;
    res_rd_idx  = '0;

    // Operands: MUL/DOT data at 0x1000 (two ops' worth), ReLU data at 0x2000.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mem[32'h1000 + 32'(k * 32 + i * 4)]      = 32'(i + 1);
        mem[32'h1000 + 32'(k * 32 + 16 + i * 4)] = 32'(i + 5);
      end
    end
    mem[32'h2000] = 32'hFFFF_FFFF;
    mem[32'h2004] = 32'd7;
    mem[32'h2008] = 32'h8000_0000;
    mem[32'h200C] = 32'd0;
    for (int i = 0; i < 4; i++) mem[32'h2010 + 32'(i * 4)] = 32'd9;

    repeat (3) @(negedge clk);
    #2;
    // Reset state
    chk("rst_busy",    {63'd0, busy},        64'd0);
    chk("rst_done",    {63'd0, done},        64'd0);
    chk("rst_error",   {63'd0, error},       64'd0);
    chk("rst_arvalid", {63'd0, axi_arvalid}, 64'd0);
    chk("rst_rready",  {63'd0, axi_rready},  64'd0);
    chk("rst_opcount", {56'd0, op_count},    64'd0);
    chk("rst_acc",     {16'd0, acc_out},     64'd0);
    chk("rst_araddr",  {32'd0, axi_araddr},  64'd0);
    chk("rst_arprot",  {61'd0, axi_arprot},  64'd0);
    rst_n = 1'b1;

    // MUL, zero-wait
    run(32'h1000, 32'h1000_0000, 8'd1);
    chk("mul_reads", nreads(), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("mul_addr%0d", i), {32'd0, rd_addr[rd_base + i]}, 64'(32'h1000 + i * 4));
    check_res("mul", 32'd5, 32'd12, 32'd21, 32'd32);
    chk("mul_opcount", {56'd0, op_count}, 64'd1);
    chk("mul_error",   {63'd0, error},    64'd0);
    // Held start must not relaunch
    repeat (5) @(negedge clk);
    #2;
    chk("hold_done",  {63'd0, done}, 64'd1);
    chk("hold_reads", nreads(),      64'd8);
    chk("hold_busy",  {63'd0, busy}, 64'd0);
    release_start();

    // DOT, two ops
    run(32'h1000, 32'h4000_0000, 8'd2);
    chk("dot_acc",     {16'd0, acc_out},  64'd140);
    chk("dot_reads",   nreads(),          64'd16);
    chk("dot_addr8",   {32'd0, rd_addr[rd_base + 8]},  64'h1020);
    chk("dot_addr15",  {32'd0, rd_addr[rd_base + 15]}, 64'h103C);
    chk("dot_opcount", {56'd0, op_count}, 64'd2);
    check_res("dot", 32'd5, 32'd12, 32'd21, 32'd32);
    release_start();

    // ReLU
    run(32'h2000, 32'h2000_0000, 8'd1);
    check_res("relu", 32'd0, 32'd7, 32'd0, 32'd0);
    chk("relu_acc", {16'd0, acc_out}, 64'd0);
    release_start();

    // ACT with non-zero sub-type passes A
    run(32'h2000, 32'h2000_0005, 8'd1);
    check_res("actpass", 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0);
    release_start();

    // NORM passes A
    run(32'h2000, 32'h3000_0000, 8'd1);
    check_res("norm", 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0);
    release_start();

    // Backpressure: arready held off 5 cycles per beat
    ar_wait = 5;
    run(32'h1000, 32'h1000_0000, 8'd1);
    ar_wait = 0;
    chk("bp_reads",  nreads(),           64'd8);
    chk("bp_stable", {63'd0, stab_err},  64'd0);
    chk("bp_addr7",  {32'd0, rd_addr[rd_base + 7]}, 64'h101C);
    check_res("bp", 32'd5, 32'd12, 32'd21, 32'd32);
    release_start();

    // Error response on beat 3
    err_beat = 3;
    run(32'h1000, 32'h1000_0000, 8'd1);
    chk("rresp_error",   {63'd0, error},    64'd1);
    chk("rresp_opcount", {56'd0, op_count}, 64'd0);
    repeat (4) @(negedge clk);
    #2;
    chk("rresp_reads", nreads(), 64'd4);
    err_beat = -1;
    release_start();

    // Illegal opcode
    run(32'h1000, 32'hF000_0000, 8'd1);
    chk("badop_error", {63'd0, error}, 64'd1);
    chk("badop_reads", nreads(),       64'd0);
    release_start();

    // op_total == 0
    run(32'h1000, 32'h1000_0000, 8'd0);
    chk("zero_error", {63'd0, error}, 64'd0);
    chk("zero_reads", nreads(),       64'd0);
    release_start();

    // Reset during the R state of op 1
    @(negedge clk);
    #2;
    base_addr   = 32'h1000;
    instruction = 32'h4000_0000;
    op_total    = 8'd2;
    rd_base     = rd_cnt;
    start       = 1'b1;
    cyc = 0;
    while (!(axi_rready && nreads() >= 64'd3) && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("midrun_in_r", {63'd0, axi_rready}, 64'd1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midrun_busy",    {63'd0, busy},        64'd0);
    chk("midrun_rready",  {63'd0, axi_rready},  64'd0);
    chk("midrun_arvalid", {63'd0, axi_arvalid}, 64'd0);
    chk("midrun_opcount", {56'd0, op_count},    64'd0);
    chk("midrun_acc",     {16'd0, acc_out},     64'd0);
    chk("midrun_araddr",  {32'd0, axi_araddr},  64'd0);
    check_res("midrun", 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run(32'h1000, 32'h1000_0000, 8'd1);
    chk("after_rst_addr0", {32'd0, rd_addr[rd_base]}, 64'h1000);
    chk("after_rst_reads", nreads(), 64'd8);
    check_res("after_rst", 32'd5, 32'd12, 32'd21, 32'd32);
    chk("after_rst_error", {63'd0, error}, 64'd0);
    release_start();

    chk("ar_during_r", {63'd0, proto_err}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
